// File: rtl/ext_bus_responder.sv
// ext_bus_responder: 16-bit bus register slave bridging to TX/RX user streams
// through two FIFOs, with a three-state handshake (IDLE/ACK/HOLD).
// Optional feature: define EXT_BUS_RESPONDER_IRQ_EN to implement IRQ_MASK and irq.
module ext_bus_responder #(
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic [10:0] avalon_bridge_address,
  input  logic        avalon_bridge_bus_enable,
  input  logic [1:0]  avalon_bridge_byte_enable,
  input  logic        avalon_bridge_rw,
  input  logic [15:0] avalon_bridge_write_data,
  output logic [15:0] avalon_bridge_read_data,
  output logic        avalon_bridge_acknowledge,
  output logic        avalon_bridge_irq,
  output logic [15:0] usr_tx_data,
  output logic        usr_tx_valid,
  input  logic        usr_tx_ready,
  input  logic [15:0] usr_rx_data,
  input  logic        usr_rx_valid,
  output logic        usr_rx_ready
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [15:0] ID_VALUE = 16'hE5D1;

  typedef enum logic [1:0] {S_IDLE, S_ACK, S_HOLD} state_t;

  state_t          r_state, w_state_nxt;
  logic            w_access;
  logic            r_ack;
  logic [15:0]     r_read_data;
  logic [15:0]     r_scratch;
  logic            r_tx_ovf, r_rx_ovf;

  logic [15:0]     r_tx_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_tx_wr, r_tx_rd;
  logic [CW-1:0]   r_tx_count;
  logic [15:0]     r_rx_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_rx_wr, r_rx_rd;
  logic [CW-1:0]   r_rx_count;

  logic            w_mapped, w_wr, w_rd;
  logic [2:0]      w_reg;
  logic            w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
  logic            w_tx_push_req, w_tx_push, w_tx_pop, w_tx_ovf_set;
  logic            w_rx_push, w_rx_pop, w_rx_ovf_set;
  logic            w_clr_tx_ovf, w_clr_rx_ovf;
  logic [15:0]     w_status, w_mask_rd, w_rd_data;

  // Access decode; an access happens only on the IDLE->ACK transition
  assign w_reg        = avalon_bridge_address[2:0];
  assign w_mapped     = (avalon_bridge_address[10:3] == 8'h00);
  assign w_wr         = w_access & ~avalon_bridge_rw & w_mapped;
  assign w_rd         = w_access &  avalon_bridge_rw & w_mapped;

  assign w_tx_full    = (r_tx_count == CW'(FIFO_DEPTH));
  assign w_tx_empty   = (r_tx_count == '0);
  assign w_rx_full    = (r_rx_count == CW'(FIFO_DEPTH));
  assign w_rx_empty   = (r_rx_count == '0);

  // A simultaneous pop frees the slot, so a push into a full FIFO is accepted then
  assign w_tx_pop      = ~w_tx_empty & usr_tx_ready;
  assign w_tx_push_req = w_wr & (w_reg == 3'd2);
  assign w_tx_push     = w_tx_push_req & (~w_tx_full | w_tx_pop);
  assign w_tx_ovf_set  = w_tx_push_req & ~w_tx_push;
  assign w_rx_pop      = w_rd & (w_reg == 3'd3) & ~w_rx_empty;
  assign w_rx_push     = usr_rx_valid & (~w_rx_full | w_rx_pop);
  assign w_rx_ovf_set  = usr_rx_valid & ~w_rx_push;
  assign w_clr_tx_ovf  = w_wr & (w_reg == 3'd5) & avalon_bridge_write_data[4];
  assign w_clr_rx_ovf  = w_wr & (w_reg == 3'd5) & avalon_bridge_write_data[5];

  assign w_status = {8'(r_rx_count), 2'b00, r_rx_ovf, r_tx_ovf,
                     w_rx_full, w_rx_empty, w_tx_empty, w_tx_full};

  // FSM state register
  always_ff @(posedge clk_clk) begin
    if (reset_reset) r_state <= S_IDLE;
    else             r_state <= w_state_nxt;
  end

  // FSM next state; bus_enable must drop before a new access is accepted
  always_comb begin
    w_state_nxt = r_state;
    w_access    = 1'b0;
    unique case (r_state)
      S_IDLE: if (avalon_bridge_bus_enable) begin
        w_state_nxt = S_ACK;
        w_access    = 1'b1;
      end
      S_ACK:  w_state_nxt = S_HOLD;
      S_HOLD: if (!avalon_bridge_bus_enable) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

`ifdef EXT_BUS_RESPONDER_IRQ_EN
  logic [1:0] r_irq_mask;
  logic       r_irq;

  // Interrupt mask (lane 0 only) and registered level interrupt
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_irq_mask <= 2'b00;
      r_irq      <= 1'b0;
    end else begin
      if (w_wr && (w_reg == 3'd4) && avalon_bridge_byte_enable[0])
        r_irq_mask <= avalon_bridge_write_data[1:0];
      r_irq <= (r_irq_mask[0] & ~w_rx_empty) | (r_irq_mask[1] & w_tx_empty);
    end
  end

  assign avalon_bridge_irq = r_irq;
  assign w_mask_rd         = {14'h0000, r_irq_mask};
`else
  assign avalon_bridge_irq = 1'b0;
  assign w_mask_rd         = 16'h0000;
`endif

  // Register read mux, evaluated against pre-access state
  always_comb begin
    w_rd_data = 16'h0000;
    if (w_mapped) begin
      unique case (w_reg)
        3'd0:    w_rd_data = ID_VALUE;
        3'd1:    w_rd_data = w_status;
        3'd3:    w_rd_data = w_rx_empty ? 16'h0000 : r_rx_mem[r_rx_rd];
        3'd4:    w_rd_data = w_mask_rd;
        3'd6:    w_rd_data = r_scratch;
        default: w_rd_data = 16'h0000;
      endcase
    end
  end

  // Acknowledge pulse, read data capture, scratch and sticky overflow flags
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_ack       <= 1'b0;
      r_read_data <= 16'h0000;
      r_scratch   <= 16'h0000;
      r_tx_ovf    <= 1'b0;
      r_rx_ovf    <= 1'b0;
    end else begin
      r_ack       <= w_access;
      r_read_data <= (w_access && avalon_bridge_rw) ? w_rd_data : 16'h0000;
      if (w_wr && (w_reg == 3'd6)) begin
        if (avalon_bridge_byte_enable[0]) r_scratch[7:0]  <= avalon_bridge_write_data[7:0];
        if (avalon_bridge_byte_enable[1]) r_scratch[15:8] <= avalon_bridge_write_data[15:8];
      end
      if (w_clr_tx_ovf) r_tx_ovf <= 1'b0;
      if (w_tx_ovf_set) r_tx_ovf <= 1'b1;
      if (w_clr_rx_ovf) r_rx_ovf <= 1'b0;
      if (w_rx_ovf_set) r_rx_ovf <= 1'b1;
    end
  end

  // TX FIFO pointers and occupancy
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_tx_wr    <= '0;
      r_tx_rd    <= '0;
      r_tx_count <= '0;
    end else begin
      if (w_tx_push) r_tx_wr <= r_tx_wr + AW'(1);
      if (w_tx_pop)  r_tx_rd <= r_tx_rd + AW'(1);
      if (w_tx_push && !w_tx_pop)      r_tx_count <= r_tx_count + CW'(1);
      else if (!w_tx_push && w_tx_pop) r_tx_count <= r_tx_count - CW'(1);
    end
  end

  // TX FIFO storage
  always_ff @(posedge clk_clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wr] <= avalon_bridge_write_data;
  end

  // RX FIFO pointers and occupancy
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_rx_wr    <= '0;
      r_rx_rd    <= '0;
      r_rx_count <= '0;
    end else begin
      if (w_rx_push) r_rx_wr <= r_rx_wr + AW'(1);
      if (w_rx_pop)  r_rx_rd <= r_rx_rd + AW'(1);
      if (w_rx_push && !w_rx_pop)      r_rx_count <= r_rx_count + CW'(1);
      else if (!w_rx_push && w_rx_pop) r_rx_count <= r_rx_count - CW'(1);
    end
  end

  // RX FIFO storage
  always_ff @(posedge clk_clk) begin
    if (w_rx_push) r_rx_mem[r_rx_wr] <= usr_rx_data;
  end

  assign avalon_bridge_acknowledge = r_ack;
  assign avalon_bridge_read_data   = r_read_data;
  assign usr_tx_valid              = ~w_tx_empty;
  assign usr_tx_data               = r_tx_mem[r_tx_rd];
  assign usr_rx_ready              = ~w_rx_full;

endmodule

// File: tb/tb_ext_bus_responder.sv
// tb_ext_bus_responder: randomized bench with a queue-based reference model;
// expected bus read data and TX stream words are checked by a separate monitor.
module tb_ext_bus_responder;

  localparam int D = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] addr = '0;
  logic        bus_en = 1'b0;
  logic [1:0]  be = 2'b00;
  logic        rw = 1'b0;
  logic [15:0] wdata = '0;
  logic [15:0] rdata;
  logic        ack;
  logic        irq;
  logic [15:0] tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [15:0] rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;

  int checks = 0;
  int errors = 0;
  int ack_count = 0;
  logic prev_ack = 1'b0;
  logic mon_en = 1'b0;

  logic [15:0] exp_q [$];
  logic [15:0] tx_q [$];
  logic [15:0] rx_q [$];
  logic        m_tx_ovf, m_rx_ovf;
  logic [1:0]  m_mask;
  logic [15:0] m_scratch;

  always #5 clk = ~clk;

  ext_bus_responder #(.FIFO_DEPTH(D)) dut (
    .clk_clk                   (clk),
    .reset_reset               (rst),
    .avalon_bridge_address     (addr),
    .avalon_bridge_bus_enable  (bus_en),
    .avalon_bridge_byte_enable (be),
    .avalon_bridge_rw          (rw),
    .avalon_bridge_write_data  (wdata),
    .avalon_bridge_read_data   (rdata),
    .avalon_bridge_acknowledge (ack),
    .avalon_bridge_irq         (irq),
    .usr_tx_data               (tx_data),
    .usr_tx_valid              (tx_valid),
    .usr_tx_ready              (tx_ready),
    .usr_rx_data               (rx_data),
    .usr_rx_valid              (rx_valid),
    .usr_rx_ready              (rx_ready)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    tx_q.delete();
    rx_q.delete();
    m_tx_ovf  = 1'b0;
    m_rx_ovf  = 1'b0;
    m_mask    = 2'b00;
    m_scratch = 16'h0000;
  endtask

  // Register map behaviour; returns the data a read must deliver
  task automatic model_access(input logic mrw, input logic [10:0] maddr,
                              input logic [15:0] mwd, input logic [1:0] mbe,
                              output logic [15:0] mrd);
    int tn;
    int rn;
    tn  = tx_q.size();
    rn  = rx_q.size();
    mrd = 16'h0000;
    if (maddr[10:3] == 8'h00) begin
      case (maddr[2:0])
        3'd0: if (mrw) mrd = 16'hE5D1;
        3'd1: if (mrw) mrd = {8'(rn), 2'b00, m_rx_ovf, m_tx_ovf,
                              rn == D, rn == 0, tn == 0, tn == D};
        3'd2: if (!mrw) begin
          if (tn < D || (tx_ready && tn > 0)) tx_q.push_back(mwd);
          else m_tx_ovf = 1'b1;
        end
        3'd3: if (mrw && rn > 0) mrd = rx_q.pop_front();
        3'd4: begin
`ifdef EXT_BUS_RESPONDER_IRQ_EN
          if (mrw) mrd = {14'h0000, m_mask};
          else if (mbe[0]) m_mask = mwd[1:0];
`endif
        end
        3'd5: if (!mrw) begin
          if (mwd[4]) m_tx_ovf = 1'b0;
          if (mwd[5]) m_rx_ovf = 1'b0;
        end
        3'd6: begin
          if (mrw) mrd = m_scratch;
          else begin
            if (mbe[0]) m_scratch[7:0]  = mwd[7:0];
            if (mbe[1]) m_scratch[15:8] = mwd[15:8];
          end
        end
        default: ;
      endcase
    end
  endtask

  // One bus transaction; rdy >= 0 also sets usr_tx_ready at issue time
  task automatic bus_access(input logic brw, input logic [10:0] baddr, input logic [15:0] bwd,
                            input logic [1:0] bbe, input int hold, input int rdy);
    logic [15:0] e;
    int a0;
    @(posedge clk); #1;
    if (rdy >= 0) tx_ready = (rdy != 0);
    model_access(brw, baddr, bwd, bbe, e);
    exp_q.push_back(e);
    a0 = ack_count;
    bus_en = 1'b1; rw = brw; addr = baddr; wdata = bwd; be = bbe;
    @(negedge clk);
    check("ack_early", 16'(ack), 16'h0000);
    @(negedge clk);
    check("ack_latency", 16'(ack), 16'h0001);
    repeat (hold) @(posedge clk);
    #1 bus_en = 1'b0;
    repeat (3) @(negedge clk);
    check("ack_count", 16'(ack_count - a0), 16'h0001);
    check("ack_pending", 16'(exp_q.size()), 16'h0000);
    exp_q.delete();
  endtask

  task automatic user_push(input logic [15:0] d);
    @(posedge clk); #1;
    check("rx_ready", 16'(rx_ready), 16'(rx_q.size() < D));
    if (rx_q.size() < D) rx_q.push_back(d);
    else m_rx_ovf = 1'b1;
    rx_valid = 1'b1; rx_data = d;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk); #1;
    tx_ready = v;
    repeat (3) @(negedge clk);
  endtask

  task automatic check_quiet();
    logic e;
`ifdef EXT_BUS_RESPONDER_IRQ_EN
    e = (m_mask[0] && rx_q.size() != 0) || (m_mask[1] && tx_q.size() == 0);
`else
    e = 1'b0;
`endif
    check("irq", 16'(irq), 16'(e));
    check("tx_valid", 16'(tx_valid), 16'(tx_q.size() != 0));
  endtask

  task automatic drain_tx();
    set_ready(1'b1);
    repeat (D + 2) @(negedge clk);
    set_ready(1'b0);
    check("tx_drained", 16'(tx_q.size()), 16'h0000);
    check_quiet();
  endtask

  // Monitor: read data against the scoreboard, single-cycle ack, TX stream order
  always @(negedge clk) begin
    if (mon_en) begin
      if (ack) begin
        ack_count++;
        check("ack_width", 16'(prev_ack), 16'h0000);
        if (exp_q.size() == 0) check("ack_unexpected", 16'(ack), 16'h0000);
        else check("read_data", rdata, exp_q.pop_front());
      end else begin
        check("read_data_idle", rdata, 16'h0000);
      end
      prev_ack = ack;
      if (tx_valid && tx_ready) begin
        if (tx_q.size() == 0) check("tx_unexpected", 16'(tx_valid), 16'h0000);
        else check("tx_data", tx_data, tx_q.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int op;
    int hold;
    logic [15:0] rw16;
    logic [1:0] rbe;
    logic [15:0] e;

    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ack", 16'(ack), 16'h0000);
    check("rst_rdata", rdata, 16'h0000);
    check("rst_irq", 16'(irq), 16'h0000);
    check("rst_tx_valid", 16'(tx_valid), 16'h0000);
    check("rst_rx_ready", 16'(rx_ready), 16'h0001);
    @(posedge clk); #1;
    rst = 1'b0;
    mon_en = 1'b1;

    // ID read with bus_enable held five cycles
    bus_access(1'b1, 11'd0, 16'h0000, 2'b11, 5, -1);
    // Per-lane scratch write and unmapped address
    bus_access(1'b0, 11'd6, 16'hAAAA, 2'b01, 1, -1);
    bus_access(1'b1, 11'd6, 16'h0000, 2'b11, 1, -1);
    bus_access(1'b0, 11'h010, 16'h5555, 2'b11, 1, -1);
    bus_access(1'b1, 11'h010, 16'h0000, 2'b11, 2, -1);
    // Two TX words held back, then streamed in order
    bus_access(1'b0, 11'd2, 16'h1234, 2'b00, 1, 0);
    bus_access(1'b0, 11'd2, 16'h5678, 2'b11, 1, -1);
    bus_access(1'b1, 11'd1, 16'h0000, 2'b11, 1, -1);
    drain_tx();
    // Overflow on ninth push, then clear
    for (int i = 0; i < 9; i++) bus_access(1'b0, 11'd2, 16'(16'h0100 + i), 2'b11, 1, -1);
    bus_access(1'b1, 11'd1, 16'h0000, 2'b11, 1, -1);
    bus_access(1'b0, 11'd5, 16'h0010, 2'b11, 1, -1);
    bus_access(1'b1, 11'd1, 16'h0000, 2'b11, 1, -1);
    drain_tx();
    // RX word, interrupt mask, pop and empty pop
    user_push(16'hBEEF);
    bus_access(1'b0, 11'd4, 16'h0001, 2'b11, 1, -1);
    check_quiet();
    bus_access(1'b1, 11'd3, 16'h0000, 2'b11, 1, -1);
    check_quiet();
    bus_access(1'b1, 11'd3, 16'h0000, 2'b11, 1, -1);

    // Randomized traffic
    for (int i = 0; i < 200; i++) begin
      op   = $urandom_range(0, 99);
      hold = $urandom_range(1, 4);
      rw16 = 16'($urandom);
      rbe  = 2'($urandom);
      if (op < 30)      bus_access(1'b0, 11'd2, rw16, rbe, hold, -1);
      else if (op < 45) bus_access(1'b1, 11'd3, rw16, rbe, hold, -1);
      else if (op < 60) user_push(rw16);
      else if (op < 68) set_ready(1'($urandom_range(0, 1)));
      else if (op < 78) bus_access(1'b1, 11'd1, rw16, rbe, hold, -1);
      else if (op < 94) bus_access(1'($urandom_range(0, 1)), 11'($urandom_range(0, 7)), rw16, rbe, hold, -1);
      else bus_access(1'($urandom_range(0, 1)),
                      {8'($urandom_range(1, 255)), 3'($urandom_range(0, 7))}, rw16, rbe, hold, -1);
      if (!tx_ready) check_quiet();
    end
    drain_tx();

    // Push into a full TX FIFO while the user side pops in the same cycle
    for (int i = 0; i < D; i++) bus_access(1'b0, 11'd2, 16'(16'hC000 + i), 2'b11, 1, -1);
    bus_access(1'b0, 11'd2, 16'hC0DE, 2'b11, 1, 1);
    drain_tx();
    bus_access(1'b1, 11'd1, 16'h0000, 2'b11, 1, -1);

    // Reset during ACK with three TX entries queued
    for (int i = 0; i < 3; i++) bus_access(1'b0, 11'd2, 16'(16'hD000 + i), 2'b11, 1, -1);
    @(posedge clk); #1;
    model_access(1'b1, 11'd0, 16'h0000, 2'b11, e);
    exp_q.push_back(e);
    bus_en = 1'b1; rw = 1'b1; addr = 11'd0; be = 2'b11;
    @(posedge clk); #1;
    check("ack_before_reset", 16'(ack), 16'h0001);
    rst = 1'b1; bus_en = 1'b0;
    @(posedge clk); #1;
    check("reset_ack", 16'(ack), 16'h0000);
    check("reset_tx_valid", 16'(tx_valid), 16'h0000);
    check("reset_rdata", rdata, 16'h0000);
    rst = 1'b0;
    model_reset();
    exp_q.delete();
    bus_access(1'b1, 11'd1, 16'h0000, 2'b11, 1, -1);
    check_quiet();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
